// File: rtl/capture_sequencer.sv
// Capture/readout sequencer for the logic analyzer sample buffer: runs the
// circular write pointer through fill/arm/post capture, then streams the frozen buffer oldest-first.
module capture_sequencer #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic                  read_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  read_last,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADR_MAX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ARMED, S_POST, S_HOLD, S_READ
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] post_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] trig_q;
  logic                  we_q;
  logic                  re_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      post_q   <= '0;
      offset_q <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      trig_q   <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The pointer tracks completed writes, so it advances even on an aborted cycle.
      if (we_q) waddr_q <= waddr_q + ADR_ONE;
      if (abort) begin
        state_q <= S_IDLE;
        we_q    <= 1'b0;
        re_q    <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              post_q  <= post_count;
              cnt_q   <= DEPTH_C - {1'b0, post_count};
              state_q <= S_FILL;
              we_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          S_FILL: begin
            if (cnt_q == CNT_ONE) state_q <= S_ARMED;
            else                  cnt_q   <= cnt_q - CNT_ONE;
          end
          S_ARMED: begin
            if (trigger) begin
              trig_q <= waddr_q;
              if (post_q == '0) begin
                state_q  <= S_HOLD;
                we_q     <= 1'b0;
                offset_q <= '0;
              end else begin
                state_q <= S_POST;
                cnt_q   <= {1'b0, post_q};
              end
            end
          end
          S_POST: begin
            if (cnt_q == CNT_ONE) begin
              state_q  <= S_HOLD;
              we_q     <= 1'b0;
              offset_q <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_HOLD, S_READ: begin
            // Once the last word is out, finish instead of issuing further reads.
            if (state_q == S_READ && last_q) begin
              state_q <= S_IDLE;
              re_q    <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              re_q   <= read_ready;
              last_q <= read_ready && (offset_q == ADR_MAX);
              if (read_ready) begin
                raddr_q  <= waddr_q + offset_q;
                offset_q <= offset_q + ADR_ONE;
                state_q  <= S_READ;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign write_enable = we_q;
  assign waddr        = waddr_q;
  assign read_enable  = re_q;
  assign raddr        = raddr_q;
  assign read_last    = last_q;
  assign trig_addr    = trig_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer; expectations come from a transaction-level
// model (write count, trigger index, oldest-first readout) derived from the capture rules.
module tb_capture_sequencer;

  localparam int AW = 3;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trigger = 1'b0;
  logic [AW-1:0] post_count = '0;
  logic          read_ready = 1'b0;
  logic          write_enable;
  logic [AW-1:0] waddr;
  logic          read_enable;
  logic [AW-1:0] raddr;
  logic          read_last;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int m_waddr = 0;
  int m_trig  = 0;

  capture_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
    .post_count(post_count), .read_ready(read_ready),
    .write_enable(write_enable), .waddr(waddr), .read_enable(read_enable),
    .raddr(raddr), .read_last(read_last), .trig_addr(trig_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_we"},   int'(write_enable), 0);
    chk({tag, "_re"},   int'(read_enable),  0);
    chk({tag, "_last"}, int'(read_last),    0);
    chk({tag, "_busy"}, int'(busy),         0);
    chk({tag, "_done"}, int'(done),         0);
  endtask

  // p: post_count, k: first cycle trigger is driven high while armed,
  // mode: read_ready pattern (0 held, 1 alternating, 2 random),
  // kind: 0 none, 1 abort, 2 reset, asserted during cycle 'at'.
  task automatic capture(input int p, input int k, input int mode, input int kind, input int at);
    int w0, t_idx, nw, fw, issued, done_c, exp_raddr, trig_old;
    bit exp_re, exp_last, fin;
    w0 = m_waddr; trig_old = m_trig;
    t_idx = (k > D - p) ? k : D - p;
    nw = t_idx + 1 + p;
    fw = (w0 + nw) % D;
    issued = 0; done_c = -1; exp_raddr = 0; exp_re = 0; exp_last = 0; fin = 0;
    arm = 1'b1; post_count = AW'(p); abort = 1'b0;
    trigger = 1'($urandom % 2); read_ready = 1'($urandom % 2);
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      if (kind != 0 && c == at + 1) begin
        check_idle(kind == 1 ? "abort" : "reset");
        if (kind == 1) begin
          m_waddr = (at < nw) ? (w0 + at + 1) % D : fw;
          m_trig  = (at > t_idx) ? (w0 + t_idx) % D : trig_old;
        end else begin
          m_waddr = 0; m_trig = 0;
          chk("reset_raddr", int'(raddr), 0);
        end
        chk("kept_waddr", int'(waddr), m_waddr);
        chk("kept_trig", int'(trig_addr), m_trig);
        fin = 1;
        break;
      end
      chk("we", int'(write_enable), int'(c < nw));
      if (c < nw) chk("waddr", int'(waddr), (w0 + c) % D);
      else        chk("waddr_hold", int'(waddr), fw);
      chk("re", int'(read_enable), int'(exp_re));
      if (exp_re) chk("raddr", int'(raddr), exp_raddr);
      chk("last", int'(read_last), int'(exp_last));
      chk("done", int'(done), int'(c == done_c));
      chk("busy", int'(busy), int'(c != done_c));
      if (c > t_idx) chk("trig_addr", int'(trig_addr), (w0 + t_idx) % D);
      if (c == done_c) begin
        m_waddr = fw; m_trig = (w0 + t_idx) % D;
        fin = 1;
        break;
      end
      arm     = 1'($urandom % 2);
      abort   = (kind == 1 && c == at);
      reset   = (kind == 2 && c == at);
      if (c < D - p)        trigger = (k == 0) ? 1'b1 : 1'($urandom % 2);
      else if (c > t_idx)   trigger = 1'($urandom % 2);
      else                  trigger = (c == t_idx);
      case (mode)
        0:       read_ready = 1'b1;
        1:       read_ready = (c >= nw) ? ((c - nw) % 2 == 0) : 1'($urandom % 2);
        default: read_ready = 1'($urandom % 2);
      endcase
      exp_re = 0; exp_last = 0;
      if (c >= nw && issued < D && read_ready) begin
        exp_re = 1;
        exp_raddr = (fw + issued) % D;
        exp_last = (issued == D - 1);
        issued++;
        if (exp_last) done_c = c + 2;
      end
      @(negedge clk);
    end
    if (!fin) chk("timeout", 0, 1);
    arm = 1'b0; abort = 1'b0; reset = 1'b0; trigger = 1'b0; read_ready = 1'b0;
    @(negedge clk);
    check_idle("after");
    chk("after_waddr", int'(waddr), m_waddr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("rst");
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_trig", int'(trig_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    capture(3, 6, 0, 0, 0);
    capture(0, 0, 0, 0, 0);
    capture(7, int'($urandom_range(0, 5)), 0, 0, 0);
    capture(3, 2, 1, 0, 0);
    capture(5, 3, 0, 1, 6);
    capture(2, 7, 2, 0, 0);
    capture(4, 0, 0, 2, 12);

    arm = 1'b1; abort = 1'b1; post_count = 3'd2;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    check_idle("arm_abort");
    chk("arm_abort_waddr", int'(waddr), m_waddr);
    @(negedge clk);
    check_idle("arm_abort2");

    for (int i = 0; i < 25; i++) begin
      int kd;
      kd = ($urandom % 4 == 0) ? 1 : 0;
      capture(int'($urandom_range(0, D - 1)), int'($urandom_range(0, D + 3)),
              int'($urandom_range(0, 2)), kd, int'($urandom_range(0, 22)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Capture/readout controller for the logic analyzer sample buffer.
- Sequences the circular write pointer through pre-trigger fill, trigger wait and post-trigger capture.
- Records the trigger address.
- Streams the frozen buffer out oldest-first through a ready/enable handshake, generating the read pointer as waddr-relative offsets.

Parameters:
- ADDR_WIDTH, 3, buffer address width; DEPTH = 2**ADDR_WIDTH samples.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- arm  in  1  start capture (IDLE only)
- abort  in  1  cancel capture/readout, return to IDLE
- trigger  in  1  trigger condition, sampled each cycle
- post_count  in  ADDR_WIDTH  samples to capture after trigger sample (latched at arm)
- read_ready  in  1  consumer accepts one word this cycle
- write_enable  out  1  buffer write strobe
- waddr  out  ADDR_WIDTH  buffer write pointer
- read_enable  out  1  buffer read strobe
- raddr  out  ADDR_WIDTH  buffer read pointer
- read_last  out  1  marks final readout word
- trig_addr  out  ADDR_WIDTH  address of trigger sample
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when readout completes

Behaviour:
- One clock. Reset is synchronous and active-high.
- All outputs and state are registered.
- Reset values:
  - state=IDLE.
  - waddr, raddr, trig_addr, all counters = 0.
  - write_enable, read_enable, read_last, busy, done = 0.
- States: IDLE, FILL, ARMED, POST, HOLD, READ.
- waddr increments mod DEPTH on every cycle write_enable is high; it wraps DEPTH-1 to 0.
- write_enable is high exactly in FILL, ARMED and POST.
- IDLE:
  - On arm, latch post_count (use post_count as is; it is at most DEPTH-1 by width).
  - Load fill counter with DEPTH - post_count, then go to FILL.
  - waddr is not reset by arm; capture continues from the current waddr.
- FILL:
  - Write each cycle and decrement the fill counter.
  - After DEPTH - post_count writes, go to ARMED.
  - trigger is ignored in FILL.
- ARMED:
  - Write each cycle.
  - When trigger=1, the sample written that cycle is the trigger sample: trig_addr <= waddr.
  - If latched post_count=0, go to HOLD; otherwise go to POST with the counter loaded to post_count.
- POST:
  - Write each cycle; trigger is ignored.
  - After post_count writes, go to HOLD.
- HOLD:
  - Buffer is frozen; waddr now points at the oldest sample.
  - Offset counter = 0. Wait for read_ready.
- READ:
  - Entered from HOLD on the first cycle read_ready=1; that same cycle counts as the first read request.
  - In HOLD/READ, each cycle read_ready=1 registers read_enable=1 and raddr = waddr + offset (mod DEPTH), then offset increments.
  - read_enable is low on cycles where read_ready=0.
  - read_last is high with the read of offset DEPTH-1.
  - The cycle after that read, go to IDLE and pulse done for one cycle.
  - Each readout issues exactly DEPTH reads.
- Latency: read_enable/raddr appear one cycle after the read_ready that requested them.
- Guaranteed full buffer: total writes ≥ (DEPTH - post_count) + 1 + post_count > DEPTH, so the buffer has always wrapped by HOLD.
- abort:
  - In any non-IDLE state, go to IDLE next cycle. Deassert write_enable and read_enable; no done pulse.
  - waddr and trig_addr are retained.
- Precedence: reset > abort > all else.
- arm outside IDLE is ignored.
- Simultaneous arm and abort in IDLE: abort wins; stay IDLE.
- Reset mid-operation returns to IDLE within one cycle, with all outputs at reset values.
- trigger held high on entry to ARMED fires on the first ARMED cycle.

Test Plan:
1. ADDR_WIDTH=3, reset, then arm with post_count=3:
   - FILL writes waddr 0..4.
   - ARMED writes 5 with trigger=0; trigger=1 at waddr=6 gives trig_addr=6.
   - POST writes 7,0,1, then HOLD with waddr=2.
   - read_ready held high: raddr 2,3,4,5,6,7,0,1, read_last with raddr=1, done one cycle later, busy=0.
2. post_count=0, trigger held high from arm:
   - FILL writes 8 samples, trigger sample written on the first ARMED cycle, HOLD next.
   - 8 reads begin at the trigger sample address + 1.
3. post_count=7:
   - FILL length is 1; trigger, then 7 post writes.
   - Readout starts at trig_addr and trig_addr appears as the first raddr.
4. Toggle read_ready 1,0,1,0 during readout:
   - read_enable follows with 1-cycle lag; raddr advances only on enabled reads.
   - Exactly 8 reads total, then done.
5. abort asserted in POST:
   - write_enable=0 next cycle, state IDLE, no done.
   - A subsequent arm restarts from the retained waddr.
6. reset asserted in READ, and arm pulsed while in ARMED:
   - reset: all outputs 0 the next cycle.
   - arm in ARMED: no effect on counters or state.
